// File: rtl/spi_poll_sched.sv
// rtl/spi_poll_sched.sv - round-robin 40-bit SPI mode-0 poller for two slaves
// Optional inter-byte gap: define SPI_POLL_BYTE_GAP_EN to insert BGAP after bits 8/16/24/32.
module spi_poll_sched #(
    parameter int CLK_DIV         = 50,
    parameter int SETUP_TICKS     = 15,
    parameter int BYTE_GAP_TICKS  = 10,
    parameter int FRAME_GAP_TICKS = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        miso,
    output logic        sclk,
    output logic [1:0]  ss_n,
    output logic [39:0] data0,
    output logic [39:0] data1,
    output logic [1:0]  valid,
    output logic        busy
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0]      SETUP_LAST = 16'(SETUP_TICKS - 1);
    localparam logic [15:0]      BGAP_LAST  = 16'(BYTE_GAP_TICKS - 1);
    localparam logic [15:0]      FGAP_LAST  = 16'(FRAME_GAP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        BGAP  = 3'd3,
        DONE  = 3'd4,
        FGAP  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      tcnt_q, tcnt_d;
    logic [5:0]       bit_q, bit_d;
    logic             phase_q, phase_d;
    logic [39:0]      shreg_q, shreg_d;
    logic             sclk_q, sclk_d;
    logic [1:0]       ss_n_q, ss_n_d;
    logic [39:0]      data0_q, data0_d;
    logic [39:0]      data1_q, data1_d;
    logic [1:0]       valid_q, valid_d;
    logic             sel_q, sel_d;
    logic             tick;
    logic [5:0]       bit_inc;

    // State and datapath registers; reset overrides any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            tcnt_q  <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            ss_n_q  <= 2'b11;
            data0_q <= '0;
            data1_q <= '0;
            valid_q <= 2'b00;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tcnt_q  <= tcnt_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            ss_n_q  <= ss_n_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    // Tick divider, frame sequencing and shift logic
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        ss_n_d  = ss_n_q;
        data0_d = data0_q;
        data1_d = data1_q;
        valid_d = 2'b00;
        sel_d   = sel_q;
        bit_inc = bit_q + 6'd1;

        // Divider parked at 0 in IDLE so every frame starts on a fresh tick boundary
        tick  = (state_q != IDLE) && (div_q == DIV_LAST);
        if (state_q == IDLE || div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SETUP;
                    tcnt_d  = '0;
                    ss_n_d  = sel_q ? 2'b01 : 2'b10;
                end
            end
            SETUP: begin
                if (tick) begin
                    if (tcnt_q == SETUP_LAST) begin
                        state_d = SHIFT;
                        tcnt_d  = '0;
                        bit_d   = '0;
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        // Rising half: sample MISO, MSB first
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[38:0], miso};
                        phase_d = 1'b1;
                    end else begin
                        // Falling half: bit complete
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        bit_d   = bit_inc;
                        if (bit_q == 6'd39) begin
                            state_d = DONE;
                        end
`ifdef SPI_POLL_BYTE_GAP_EN
                        else if (bit_inc[2:0] == 3'd0) begin
                            state_d = BGAP;
                            tcnt_d  = '0;
                        end
`endif
                    end
                end
            end
            BGAP: begin
                // Only reachable when the byte gap is compiled in
                if (tick) begin
                    if (tcnt_q == BGAP_LAST) begin
                        state_d = SHIFT;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
            end
            DONE: begin
                ss_n_d  = 2'b11;
                state_d = FGAP;
                tcnt_d  = '0;
                sel_d   = ~sel_q;
                if (sel_q) begin
                    data1_d = shreg_q;
                    valid_d = 2'b10;
                end else begin
                    data0_d = shreg_q;
                    valid_d = 2'b01;
                end
            end
            FGAP: begin
                if (tick) begin
                    if (tcnt_q == FGAP_LAST) begin
                        state_d = IDLE;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ss_n_d  = 2'b11;
                sclk_d  = 1'b0;
            end
        endcase
    end

    assign sclk  = sclk_q;
    assign ss_n  = ss_n_q;
    assign data0 = data0_q;
    assign data1 = data1_q;
    assign valid = valid_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_spi_poll_sched.sv
// tb/tb_spi_poll_sched.sv - directed self-checking bench for spi_poll_sched
module tb_spi_poll_sched;

    localparam logic [39:0] PAT0 = 40'h1122334455;
    localparam logic [39:0] PAT1 = 40'hA5A5C3C30F;
`ifdef SPI_POLL_BYTE_GAP_EN
    localparam int EXP_W = 344;
`else
    localparam int EXP_W = 328;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        miso;
    logic        sclk;
    logic [1:0]  ss_n;
    logic [39:0] data0;
    logic [39:0] data1;
    logic [1:0]  valid;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    spi_poll_sched #(
        .CLK_DIV(4), .SETUP_TICKS(2), .BYTE_GAP_TICKS(1), .FRAME_GAP_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .miso(miso), .sclk(sclk),
        .ss_n(ss_n), .data0(data0), .data1(data1), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave model: mode 0, next bit presented after each SCLK falling edge
    int   idx = 0;
    logic sclk_prev = 1'b0;
    always @(posedge clk) begin
        if (ss_n == 2'b11) idx <= 0;
        else if (sclk_prev && !sclk && idx < 40) idx <= idx + 1;
        sclk_prev <= sclk;
    end
    always_comb begin
        miso = 1'b0;
        if (idx < 40) begin
            if (ss_n == 2'b10) miso = PAT0[39 - idx];
            else if (ss_n == 2'b01) miso = PAT1[39 - idx];
        end
    end

    // Bus monitor sampled on the falling clk edge
    int         ss_w = 0, last_w = 0, rises = 0, rises_total = 0;
    int         overlap = 0, sclk_desel = 0;
    logic [1:0] ss_seen = 2'b11, ss_prev = 2'b11;
    logic       sclk_mon = 1'b0;
    always @(negedge clk) begin
        if (ss_n != 2'b11) begin
            if (ss_prev == 2'b11) rises = 0;
            ss_w    = ss_w + 1;
            ss_seen = ss_n;
        end else if (ss_prev != 2'b11) begin
            last_w = ss_w;
            ss_w   = 0;
        end
        if (sclk && !sclk_mon) begin
            rises       = rises + 1;
            rises_total = rises_total + 1;
        end
        if (ss_n == 2'b00) overlap = overlap + 1;
        if (ss_n == 2'b11 && sclk) sclk_desel = sclk_desel + 1;
        ss_prev  = ss_n;
        sclk_mon = sclk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output logic [1:0] v);
        v = 2'b00;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (valid != 2'b00) begin
                v = valid;
                break;
            end
        end
        if (v == 2'b00) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rises(input int n);
        int i;
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (rises >= n && ss_n != 2'b11) break;
        end
        if (i == 5000) check("rises_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [1:0] v;
        int         i;
        int         snap;

        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ss_n", 64'(ss_n), 64'h3);
        check("rst_sclk", 64'(sclk), 64'h0);
        check("rst_data0", 64'(data0), 64'h0);
        check("rst_data1", 64'(data1), 64'h0);
        check("rst_valid", 64'(valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst    = 1'b0;
        enable = 1'b1;

        // Frame 1: slave 0
        wait_valid(v);
        check("f1_valid", 64'(v), 64'h1);
        check("f1_data0", 64'(data0), 64'(PAT0));
        check("f1_data1", 64'(data1), 64'h0);
        check("f1_ss_sel", 64'(ss_seen), 64'h2);
        check("f1_rises", 64'(rises), 64'd40);
        @(negedge clk);
        check("f1_valid_1clk", 64'(valid), 64'h0);
        check("f1_ss_width", 64'((last_w >= EXP_W - 4) && (last_w <= EXP_W + 4)), 64'd1);

        // Frame 2: slave 1
        wait_valid(v);
        check("f2_valid", 64'(v), 64'h2);
        check("f2_data1", 64'(data1), 64'(PAT1));
        check("f2_data0_held", 64'(data0), 64'(PAT0));
        check("f2_ss_sel", 64'(ss_seen), 64'h1);
        check("f2_rises", 64'(rises), 64'd40);

        // Frame 3: enable dropped during bit 20, frame must still finish
        wait_rises(20);
        enable = 1'b0;
        wait_valid(v);
        check("f3_valid", 64'(v), 64'h1);
        check("f3_data0", 64'(data0), 64'(PAT0));
        check("f3_rises", 64'(rises), 64'd40);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("f3_idle_busy", 64'(busy), 64'h0);
        check("f3_idle_ss_n", 64'(ss_n), 64'h3);
        snap = rises_total;
        repeat (200) @(negedge clk);
        check("f3_no_sclk", 64'(rises_total), 64'(snap));
        check("f3_stay_idle", 64'(busy), 64'h0);

        // Frame 4 (slave 1) interrupted by reset during bit 10
        enable = 1'b1;
        wait_rises(10);
        check("f4_ss_sel", 64'(ss_n), 64'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("r_ss_n", 64'(ss_n), 64'h3);
        check("r_sclk", 64'(sclk), 64'h0);
        check("r_data0", 64'(data0), 64'h0);
        check("r_data1", 64'(data1), 64'h0);
        check("r_busy", 64'(busy), 64'h0);
        rst = 1'b0;

        // First frame after reset goes back to slave 0
        wait_valid(v);
        check("f5_valid", 64'(v), 64'h1);
        check("f5_ss_sel", 64'(ss_seen), 64'h2);
        check("f5_data0", 64'(data0), 64'(PAT0));
        check("f5_data1", 64'(data1), 64'h0);

        check("ss_overlap", 64'(overlap), 64'd0);
        check("sclk_deselected", 64'(sclk_desel), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
